pwm_compare: RTL and testbench

Compare/PWM stage that sits directly downstream of the mod-N counter. It samples the counter's `q` output every clock and detects counter wrap-around. It compares `q` against a double-buffered duty value to produce a glitch-free PWM output, and counts completed periods. Duty updates arrive over a valid/ready handshake and take effect only at a wrap boundary.

---
 rtl/pwm_cfg_if.sv | 10 +
 rtl/pwm_compare.sv | 100 ++++++++++
 tb/tb_pwm_compare.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_if.sv
// Duty-configuration handshake between a duty source and the PWM compare stage.
// The source holds cfg_duty stable while cfg_valid is high and cfg_ready is low.
interface pwm_cfg_if #(parameter int N = 8);
   logic         cfg_valid;
   logic [N:0]   cfg_duty;
   logic         cfg_ready;

   modport master (output cfg_valid, output cfg_duty, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_duty, output cfg_ready);
endinterface

// File: rtl/pwm_compare.sv
// PWM compare stage behind a mod-N counter: one-cycle q->pwm_out latency, duty double-buffered to wrap.
// Single-entry duty buffer; cfg_ready stays low from an accept until the wrap that applies the value.
module pwm_compare #(
   parameter int N   = 8,
   parameter int PCW = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   q,
   input  logic           en,
   pwm_cfg_if.slave       cfg,
   output logic           pwm_out,
   output logic           wrap_pulse,
   output logic [PCW-1:0] period_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t       state;
   state_t       state_next;
   logic [N-1:0] q_prev;
   logic         prev_valid;
   logic [N:0]   duty_active;
   logic [N:0]   duty_pend;
   logic         pend_full;
   logic         wrap;
   logic         accept;
   logic [N:0]   duty_eff;
   logic         cmp;

   assign wrap          = prev_valid && (q < q_prev);
   assign cfg.cfg_ready = !pend_full;
   assign accept        = cfg.cfg_valid && !pend_full;
   // The wrap cycle already belongs to the new period, so it must see the new duty.
   assign duty_eff      = (wrap && pend_full) ? duty_pend : duty_active;
   assign cmp           = ({1'b0, q} < duty_eff);

   always_comb begin
      state_next = state;
      if (!en) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = SYNC;
            SYNC:    if (wrap) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         q_prev     <= '0;
         prev_valid <= 1'b0;
         wrap_pulse <= 1'b0;
         pwm_out    <= 1'b0;
      end else begin
         state      <= state_next;
         q_prev     <= q;
         prev_valid <= 1'b1;
         wrap_pulse <= wrap;
         pwm_out    <= (state_next == RUN) && cmp;
      end
   end

   // A new value can only land when the buffer is empty, so accept and apply never collide.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         duty_active <= '0;
         duty_pend   <= '0;
         pend_full   <= 1'b0;
      end else begin
         if (wrap && pend_full) begin
            duty_active <= duty_pend;
            pend_full   <= 1'b0;
         end
         if (accept) begin
            duty_pend <= cfg.cfg_duty;
            pend_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt <= '0;
      end else if (state_next == IDLE) begin
         period_cnt <= '0;
      end else if (wrap && (state_next == RUN) && (period_cnt != '1)) begin
         period_cnt <= period_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare with N=3, PCW=2; q is driven 0..7 by the bench itself.
module tb_pwm_compare;

   logic       clk;
   logic       reset;
   logic [2:0] q;
   logic       en;
   logic       pwm_out;
   logic       wrap_pulse;
   logic [1:0] period_cnt;
   int         n_chk;
   int         n_err;

   pwm_cfg_if #(.N(3)) cfg_if ();

   pwm_compare #(.N(3), .PCW(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .q          (q),
      .en         (en),
      .cfg        (cfg_if),
      .pwm_out    (pwm_out),
      .wrap_pulse (wrap_pulse),
      .period_cnt (period_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that sampled qv.
   task automatic tick(input logic [2:0] qv);
      logic hs;
      q  = qv;
      hs = cfg_if.cfg_valid && cfg_if.cfg_ready;
      @(posedge clk);
      #1;
      if (hs) cfg_if.cfg_valid = 1'b0;
   endtask

   // One full counter period q=0..7; exp bit i is the pwm_out expected after q=i is sampled.
   task automatic period(input string tag, input logic [7:0] exp, input int offer_idx,
                         input logic [3:0] offer_duty, input int rdy_idx, input logic rdy_exp,
                         input logic rdy_end, input logic [1:0] cnt_end);
      for (int i = 0; i < 8; i++) begin
         if (i == offer_idx) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_duty  = offer_duty;
         end
         tick(3'(i));
         chk({tag, "_pwm"}, pwm_out, exp[i]);
         chk({tag, "_wrap"}, wrap_pulse, (i == 0));
         if (i == rdy_idx) chk({tag, "_rdy_mid"}, cfg_if.cfg_ready, rdy_exp);
      end
      chk({tag, "_rdy_end"}, cfg_if.cfg_ready, rdy_end);
      chk({tag, "_cnt"}, period_cnt, cnt_end);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      reset = 1'b0;
      en    = 1'b0;
      q     = 3'd0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_duty  = '0;
      #1;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_wrap", wrap_pulse, 0);
      chk("rst_rdy", cfg_if.cfg_ready, 1);
      chk("rst_cnt", period_cnt, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Load duty 3 while idle; it applies at the first wrap even with en low.
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_duty  = 4'd3;
      tick(3'd0);
      chk("idle_rdy_drop", cfg_if.cfg_ready, 0);
      chk("first_nowrap", wrap_pulse, 0);
      for (int i = 1; i < 8; i++) tick(3'(i));
      tick(3'd0);
      chk("idle_wrap", wrap_pulse, 1);
      chk("idle_rdy_back", cfg_if.cfg_ready, 1);
      chk("idle_cnt", period_cnt, 0);
      chk("idle_pwm", pwm_out, 0);

      // SYNC: no PWM until the wrap.
      en = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick(3'(i));
         chk("sync_pwm", pwm_out, 0);
         chk("sync_wrap", wrap_pulse, 0);
      end

      period("p1", 8'h07, 8, 4'd0, 0, 1'b1, 1'b1, 2'd1);
      period("p2", 8'h07, 4, 4'd6, 4, 1'b0, 1'b0, 2'd2);
      // Duty 1 offered while full: refused at the wrap, accepted the cycle after.
      period("p3", 8'h3F, 0, 4'd1, 0, 1'b1, 1'b0, 2'd3);
      period("p4", 8'h01, 8, 4'd0, 0, 1'b1, 1'b1, 2'd3);
      // Accept coinciding with a wrap: duty 0 waits for the following wrap.
      period("p5", 8'h01, 0, 4'd0, 0, 1'b0, 1'b0, 2'd3);
      period("p6", 8'h00, 3, 4'd8, 3, 1'b0, 1'b0, 2'd3);
      period("p7", 8'hFF, 8, 4'd0, 0, 1'b1, 1'b1, 2'd3);

      // Drop en mid-RUN.
      tick(3'd0);
      tick(3'd1);
      tick(3'd2);
      chk("pre_drop_pwm", pwm_out, 1);
      en = 1'b0;
      tick(3'd3);
      chk("drop_pwm", pwm_out, 0);
      chk("drop_cnt", period_cnt, 0);
      tick(3'd4);
      chk("drop_pwm2", pwm_out, 0);

      // Raise en at q=5: low until the wrap.
      en = 1'b1;
      for (int i = 5; i < 8; i++) begin
         tick(3'(i));
         chk("raise_pwm", pwm_out, 0);
      end
      tick(3'd0);
      chk("raise_wrap_pwm", pwm_out, 1);
      chk("raise_cnt", period_cnt, 1);

      // Async reset mid-period with a pending duty.
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_duty  = 4'd5;
      tick(3'd1);
      chk("pre_rst_rdy", cfg_if.cfg_ready, 0);
      tick(3'd2);
      chk("pre_rst_pwm", pwm_out, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_pwm", pwm_out, 0);
      chk("arst_wrap", wrap_pulse, 0);
      chk("arst_rdy", cfg_if.cfg_ready, 1);
      chk("arst_cnt", period_cnt, 0);
      cfg_if.cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(3'd3);
      chk("post_rst_nowrap", wrap_pulse, 0);
      chk("post_rst_rdy", cfg_if.cfg_ready, 1);
      for (int i = 4; i < 8; i++) tick(3'(i));
      // Pending duty 5 was discarded, so the new RUN period uses duty 0.
      period("p_post", 8'h00, 8, 4'd0, 0, 1'b1, 1'b1, 2'd1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
